// File: rtl/stock_result_scheduler.sv
// Round-robin scheduler that buffers one 40-bit result per stock weight engine
// and issues them one at a time onto the shared serializer path.
module stock_result_scheduler #(
    parameter int unsigned N_STOCKS    = 11,
    parameter int unsigned DATA_W      = 40,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_STOCKS-1:0]        ready_in,
    input  logic [N_STOCKS*DATA_W-1:0] data_in,
    input  logic                       downstream_busy,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    output logic [N_STOCKS-1:0]        pending,
    output logic [N_STOCKS-1:0]        overrun
);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                state_q;
    logic [DATA_W-1:0]     hold_q [N_STOCKS];
    logic [N_STOCKS-1:0]   pending_q, pending_d;
    logic [N_STOCKS-1:0]   overrun_q, overrun_d;
    logic [ID_W-1:0]       last_id_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  out_valid_q;
    logic [DATA_W-1:0]     out_data_q;
    logic [ID_W-1:0]       out_id_q;

    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       cand;
    logic [N_STOCKS-1:0]   issue_oh;
    logic                  issue;

    // Scan from the farthest offset down so the nearest pending stock after last_id wins.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = N_STOCKS; k > 0; k--) begin
            cand = ID_W'((32'(last_id_q) + k) % N_STOCKS);
            if (pending_q[cand]) begin
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        issue    = (state_q == IDLE) && (pending_q != '0) && !downstream_busy;
        issue_oh = '0;
        if (issue) begin
            issue_oh[grant_idx] = 1'b1;
        end
    end

    // A fresh capture beats the grant clear; granting the old value is not an overrun.
    always_comb begin
        pending_d = ready_in | (pending_q & ~issue_oh);
        overrun_d = overrun_q | (ready_in & pending_q & ~issue_oh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    for (genvar i = 0; i < N_STOCKS; i++) begin : g_hold
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q[i] <= '0;
            end else if (ready_in[i]) begin
                hold_q[i] <= data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_id_q   <= ID_W'(N_STOCKS - 1);
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q     <= ISSUE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= hold_q[grant_idx];
                        out_id_q    <= grant_idx;
                        last_id_q   <= grant_idx;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_ACK;
                    cnt_q   <= '0;
                end
                WAIT_ACK: begin
                    if (downstream_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!downstream_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_stock_result_scheduler.sv
// Self-checking bench for stock_result_scheduler: randomized stimulus compared
// each cycle against a transaction-level reference model, plus directed checks.
module tb_stock_result_scheduler;
    localparam int N = 11;
    localparam int W = 40;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   ready_r;
    logic [N*W-1:0] data_r;
    logic           busy_r;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [3:0]     out_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   overrun;

    stock_result_scheduler #(
        .N_STOCKS   (N),
        .DATA_W     (W),
        .ID_W       (4),
        .ACK_TIMEOUT(T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready_in       (ready_r),
        .data_in        (data_r),
        .downstream_busy(busy_r),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_id         (out_id),
        .pending        (pending),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: buffered results, flags, round-robin position, handshake phase.
    logic [W-1:0] m_hold [N];
    logic [N-1:0] m_pend, m_ovr;
    int           m_last;
    int           m_phase;  // 0 idle, 1 issuing, 2 awaiting busy, 3 downstream busy
    int           m_cnt;
    logic         m_valid;
    logic [3:0]   m_id;
    logic [W-1:0] m_data;

    // Downstream emulator: busy rises ds_rise cycles after an issue, for ds_len cycles.
    bit ds_auto;
    bit ds_on;
    int ds_cnt, ds_rise, ds_len;

    logic [66:0] dut_vec, mdl_vec;
    assign dut_vec = {out_valid, out_id, out_data, pending, overrun};
    assign mdl_vec = {m_valid, m_id, m_data, m_pend, m_ovr};

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        m_pend = '0; m_ovr = '0; m_last = N - 1; m_phase = 0; m_cnt = 0;
        m_valid = 1'b0; m_id = '0; m_data = '0;
        ds_on = 1'b0; ds_cnt = 0;
    endtask

    task automatic model_step();
        int g;
        bit iss;
        iss = (m_phase == 0) && (m_pend != '0) && !busy_r;
        g = -1;
        m_valid = 1'b0;
        if (iss) begin
            // nearest pending stock at distance 1..N after the last grant
            for (int d = N; d >= 1; d--) if (m_pend[(m_last + d) % N]) g = (m_last + d) % N;
            m_valid = 1'b1; m_id = 4'(g); m_data = m_hold[g]; m_last = g;
        end
        for (int i = 0; i < N; i++) begin
            if (ready_r[i]) begin
                if (m_pend[i] && i != g) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_hold[i] = data_r[i*W +: W];
            end else if (i == g) begin
                m_pend[i] = 1'b0;
            end
        end
        case (m_phase)
            0: if (iss) m_phase = 1;
            1: begin m_phase = 2; m_cnt = 0; end
            2: if (busy_r) m_phase = 3; else if (m_cnt == T - 1) m_phase = 0; else m_cnt++;
            default: if (!busy_r) m_phase = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        ready_r = '0;
        for (int i = 0; i < N; i++) data_r[i*W +: W] = {8'($urandom), $urandom};
        if (ds_auto) begin
            if (m_valid) begin ds_on = 1'b1; ds_cnt = 0; end
            else if (ds_on) ds_cnt++;
            busy_r = ds_on && ds_cnt >= ds_rise && ds_cnt < ds_rise + ds_len;
            if (ds_on && ds_cnt >= ds_rise + ds_len) ds_on = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ready_r = '0; busy_r = 1'b0; ds_auto = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== 67'd0) $display("FAIL reset_outputs: got %h expected 0", dut_vec);
        else n_pass++;
    endtask

    task automatic test_single();
        int issues = 0;
        ds_auto = 1'b1; ds_rise = 2; ds_len = 20;
        ready_r[3] = 1'b1; data_r[3*W +: W] = 40'h00_1234_5678;
        tick();
        n_checks++;
        if (pending !== 11'b000_0000_1000 || out_valid !== 1'b0)
            $display("FAIL t1_cycle1: got pend=%b v=%b expected pend=00000001000 v=0", pending, out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({out_valid, out_id, out_data, pending} !== {1'b1, 4'd3, 40'h0012345678, 11'd0})
            $display("FAIL t1_issue: got v=%b id=%0d data=%h pend=%b expected v=1 id=3 data=0012345678 pend=0",
                     out_valid, out_id, out_data, pending);
        else n_pass++;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (out_valid) issues++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL t1_cycle%0d: got %h expected %h", c, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (issues !== 0) $display("FAIL t1_no_reissue: got %0d issues expected 0", issues);
        else n_pass++;
    endtask

    task automatic test_pair();
        int ids[$];
        do_reset();
        ds_auto = 1'b1; ds_rise = 2; ds_len = 5;
        ready_r[0] = 1'b1; ready_r[10] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid) ids.push_back(int'(out_id));
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL t2_cycle%0d: got %h expected %h", c, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (ids.size() != 2 || ids[0] != 0 || ids[1] != 10 || pending !== '0)
            $display("FAIL t2_order: got %0d issues first=%0d pend=%b expected ids 0,10 pend=0",
                     ids.size(), (ids.size() > 0) ? ids[0] : -1, pending);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int ids[$];
        int exp_ids[6] = '{2, 5, 9, 2, 5, 9};
        bit ok;
        do_reset();
        ds_auto = 1'b1; ds_rise = 1; ds_len = 3;
        for (int c = 0; c < 300 && ids.size() < 6; c++) begin
            ready_r[2] = 1'b1; ready_r[5] = 1'b1; ready_r[9] = 1'b1;
            tick();
            if (out_valid) ids.push_back(int'(out_id));
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL t3_cycle%0d: got %h expected %h", c, dut_vec, mdl_vec);
            else n_pass++;
        end
        ok = (ids.size() == 6);
        for (int k = 0; k < 6 && ok; k++) if (ids[k] != exp_ids[k]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL t3_order: got %0d issues expected order 2,5,9,2,5,9", ids.size());
        else n_pass++;
        for (int c = 0; c < 60; c++) begin
            if (($urandom & 3) == 0) ready_r[$urandom_range(0, N - 1)] = 1'b1;
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL t3_rand%0d: got %h expected %h", c, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        int issues = 0;
        logic [W-1:0] last_data = '0;
        do_reset();
        busy_r = 1'b1;
        ready_r[7] = 1'b1; data_r[7*W +: W] = 40'hAA;
        tick(); tick();
        ready_r[7] = 1'b1; data_r[7*W +: W] = 40'hBB;
        tick(); tick();
        n_checks++;
        if (overrun[7] !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL t4_overrun: got ovr=%b v=%b expected ovr[7]=1 v=0", overrun, out_valid);
        else n_pass++;
        busy_r = 1'b0; ds_auto = 1'b1; ds_rise = 2; ds_len = 3;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid) begin issues++; last_data = out_data; end
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL t4_cycle%0d: got %h expected %h", c, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (issues != 1 || last_data !== 40'hBB)
            $display("FAIL t4_single_issue: got %0d issues data=%h expected 1 issue data=00000000bb", issues, last_data);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int t_first = -1, t_second = -1, second_id = -1;
        do_reset();
        ready_r[1] = 1'b1; ready_r[4] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (out_valid) begin
                if (t_first < 0) t_first = c;
                else if (t_second < 0) begin t_second = c; second_id = int'(out_id); end
            end
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL t5_cycle%0d: got %h expected %h", c, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (t_first < 0 || t_second < 0 || t_second - t_first < T + 1 || t_second - t_first > T + 3 || second_id != 4)
            $display("FAIL t5_timeout: got gap=%0d id=%0d expected gap %0d..%0d id=4",
                     t_second - t_first, second_id, T + 1, T + 3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int issues = 0;
        do_reset();
        ds_auto = 1'b1; ds_rise = 1; ds_len = 50;
        ready_r[1] = 1'b1;
        tick(); tick(); tick();
        ready_r[3] = 1'b1; ready_r[6] = 1'b1; ready_r[8] = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        n_checks++;
        if (pending !== 11'b001_0100_1000 || busy_r !== 1'b1)
            $display("FAIL t6_pre: got pend=%b busy=%b expected pend=00101001000 busy=1", pending, busy_r);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 67'd0) $display("FAIL t6_async_clear: got %h expected 0", dut_vec);
        else n_pass++;
        ds_auto = 1'b0; busy_r = 1'b0; ready_r = '0;
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) issues++;
        end
        n_checks++;
        if (issues != 0 || pending !== '0) $display("FAIL t6_no_issue: got %0d issues pend=%b expected 0", issues, pending);
        else n_pass++;
        ready_r[5] = 1'b1;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 4'd5 || dut_vec !== mdl_vec)
            $display("FAIL t6_new_issue: got v=%b id=%0d expected v=1 id=5", out_valid, out_id);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; ready_r = '0; data_r = '0; busy_r = 1'b0;
        test_reset();
        test_single();
        test_pair();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
